seq_divider_32: RTL and testbench

- Multi-cycle signed integer divider for the Mini-SRC ALU datapath; it complements the combinational carry-lookahead adder family.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using a non-restoring add/subtract recurrence, one quotient bit per clock.
- The control unit starts it with a start/busy/done handshake. The quotient goes to LO and the remainder to HI.

---
 rtl/seq_divider_32.sv | 77 +++++++
 tb/tb_seq_divider_32.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// seq_divider_32: multi-cycle signed divider, non-restoring recurrence, one quotient bit per clock.
// Quotient goes to LO, remainder (sign of dividend) to HI; fixed latency for every operand.
module seq_divider_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_div_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] count;
   logic [WIDTH-1:0] q, b;
   logic [WIDTH:0] p, p_sh, p_nx, p_fix;
   logic sign_a, sign_b, zero;
   // q doubles as the dividend shift register; its MSB feeds the partial remainder
   assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
   assign p_nx = p[WIDTH] ? p_sh + {1'b0, b} : p_sh - {1'b0, b};
   assign p_fix = p[WIDTH] ? p + {1'b0, b} : p;
   always_ff @(posedge clk)
      state <= clr ? IDLE : state_nx;
   always_comb
      state_nx = state == IDLE ? (in_start ? CALC : IDLE) :
                 state == CALC ? (count == CW'(1) ? FIX : CALC) :
                 state == FIX  ? DONE : IDLE;
   always_comb begin
      out_busy = state == CALC || state == FIX;
      out_done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
         p <= '0;
         q <= '0;
         b <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         zero <= 1'b0;
         out_quotient <= '0;
         out_remainder <= '0;
         out_div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_start) begin
               q <= in_dividend[WIDTH-1] ? -in_dividend : in_dividend;
               b <= in_divisor[WIDTH-1] ? -in_divisor : in_divisor;
               sign_a <= in_dividend[WIDTH-1];
               sign_b <= in_divisor[WIDTH-1];
               zero <= in_divisor == '0;
               p <= '0;
               count <= CW'(WIDTH);
               out_div_zero <= 1'b0;
            end
            CALC: begin
               p <= p_nx;
               q <= {q[WIDTH-2:0], ~p_nx[WIDTH]};
               count <= count - CW'(1);
            end
            FIX: begin
               // a zero divisor leaves q all ones and p = |dividend|, so only the quotient sign needs overriding
               out_quotient <= zero ? '1 : (sign_a ^ sign_b) ? -q : q;
               out_remainder <= sign_a ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
               out_div_zero <= zero;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: directed vectors with a scoreboard queue checked by an out_done monitor.
module tb_seq_divider_32;
   localparam int W = 32;
   logic clk = 0, clr = 1, in_start = 0;
   logic [W-1:0] in_dividend = '0, in_divisor = '0;
   logic [W-1:0] out_quotient, out_remainder;
   logic out_busy, out_done, out_div_zero;
   seq_divider_32 #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .in_start(in_start), .in_dividend(in_dividend), .in_divisor(in_divisor),
      .out_quotient(out_quotient), .out_remainder(out_remainder), .out_busy(out_busy),
      .out_done(out_done), .out_div_zero(out_div_zero)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic dz; int at;} exp_t;
   exp_t sb[$];
   exp_t cur;
   int n_cmp = 0, n_bad = 0;
   logic prev_done = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (out_done) begin
         if (sb.size() == 0) chk("unexpected_done", 64'(out_done), 64'(0));
         else begin
            cur = sb.pop_front();
            chk("quotient", 64'(out_quotient), 64'(cur.q));
            chk("remainder", 64'(out_remainder), 64'(cur.r));
            chk("div_zero", 64'(out_div_zero), 64'(cur.dz));
            chk("done_cycle", 64'(cyc), 64'(cur.at));
            chk("busy_at_done", 64'(out_busy), 64'(0));
         end
         if (prev_done) chk("done_width", 64'(1), 64'(0));
      end
      prev_done <= out_done;
   end
   task automatic start_div(input logic [W-1:0] a, d, qe, re, input logic dz, input logic push);
      @(negedge clk);
      in_start = 1;
      in_dividend = a;
      in_divisor = d;
      @(posedge clk);
      #1;
      in_start = 0;
      in_dividend = $urandom;
      in_divisor = $urandom;
      if (push) sb.push_back('{qe, re, dz, cyc + W + 1});
   endtask
   task automatic wait_done();
      int n = 0;
      while (!out_done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 64'(out_done), 64'(1));
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_quotient", 64'(out_quotient), 64'(0));
      chk("rst_remainder", 64'(out_remainder), 64'(0));
      chk("rst_busy", 64'(out_busy), 64'(0));
      chk("rst_done", 64'(out_done), 64'(0));
      chk("rst_div_zero", 64'(out_div_zero), 64'(0));
      clr = 0;
      start_div(100, 7, 14, 2, 0, 1);
      @(negedge clk);
      chk("busy_cycle1", 64'(out_busy), 64'(1));
      repeat (31) @(negedge clk);
      chk("busy_cycle32", 64'(out_busy), 64'(1));
      chk("done_cycle32", 64'(out_done), 64'(0));
      wait_done();
      start_div(-32'sd100, 7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 1); wait_done();
      start_div(100, -32'sd7, 32'hFFFF_FFF2, 2, 0, 1); wait_done();
      start_div(-32'sd100, -32'sd7, 14, 32'hFFFF_FFFE, 0, 1); wait_done();
      start_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1); wait_done();
      start_div(32'h8000_0000, 32'h8000_0000, 1, 0, 0, 1); wait_done();
      start_div(5, 9, 0, 5, 0, 1); wait_done();
      start_div(1234, 0, 32'hFFFF_FFFF, 1234, 1, 1); wait_done();
      start_div(6, 3, 2, 0, 0, 1);
      chk("div_zero_cleared", 64'(out_div_zero), 64'(1'b0));
      wait_done();
      start_div(-32'sd7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 1); wait_done();
      start_div(50, 5, 10, 0, 0, 1);
      repeat (9) @(negedge clk);
      in_start = 1; in_dividend = 9; in_divisor = 3;
      @(negedge clk);
      in_start = 0;
      wait_done();
      repeat (3) @(negedge clk);
      start_div(1000, 3, 0, 0, 0, 0);
      repeat (14) @(negedge clk);
      clr = 1;
      @(negedge clk);
      clr = 0;
      chk("clr_busy", 64'(out_busy), 64'(0));
      chk("clr_quotient", 64'(out_quotient), 64'(0));
      chk("clr_remainder", 64'(out_remainder), 64'(0));
      repeat (40) @(negedge clk);
      in_start = 1; clr = 1; in_dividend = 8; in_divisor = 2;
      @(negedge clk);
      in_start = 0; clr = 0;
      chk("clr_start_busy", 64'(out_busy), 64'(0));
      start_div(1000, 3, 333, 1, 0, 1); wait_done();
      repeat (40) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
